// File: rtl/prog_loader.sv
// prog_loader: frames, checks and assembles 46-bit program lines from a
// valid/ready byte stream and writes them into the MCX program memory.
// Write frame: 0xA5, address, six data bytes (MSB first), checksum.
// A malformed frame is still consumed in full so the stream stays aligned.
// Run command 0x5A releases the core hold.
module prog_loader #(
  parameter int ADDR_W = 4,
  parameter int LINE_W = 46
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_in_data,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [LINE_W-1:0] o_wr_line,
  output logic              o_core_hold,
  output logic              o_busy,
  output logic [1:0]        o_err,
  output logic [4:0]        o_lines_written
);

  localparam logic [7:0] CMD_WRITE = 8'hA5;
  localparam logic [7:0] CMD_RUN   = 8'h5A;
  localparam logic [2:0] LAST_DATA = 3'd5;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_ADDR = 2'd1;
  localparam logic [1:0] ERR_PAD  = 2'd2;
  localparam logic [1:0] ERR_CSUM = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_CSUM  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic              w_xfer;
  logic              w_csum_bad;
  logic              w_frame_ok;
  logic [1:0]        w_err_code;

  logic [ADDR_W-1:0] r_frame_addr;
  // Only the low LINE_W bits of the assembled 48 bits ever reach the
  // memory, so the shift register keeps just those; the two top bits of
  // the first data byte are checked as pad instead.
  logic [LINE_W-1:0] r_shift;
  logic [7:0]        r_xor;
  logic [2:0]        r_cnt;
  logic              r_addr_bad;
  logic              r_pad_bad;

  // Handshake readiness depends on state only: the single WRITE cycle refuses bytes.
  always_comb begin
    o_in_ready = 1'b1;
    if (r_state == S_WRITE) begin
      o_in_ready = 1'b0;
    end else begin
      o_in_ready = 1'b1;
    end
  end

  // Transfer detection and the frame verdict evaluated as the checksum byte arrives.
  always_comb begin
    w_xfer     = i_in_valid && o_in_ready;
    w_csum_bad = (i_in_data != r_xor);
    w_frame_ok = !(w_csum_bad || r_addr_bad || r_pad_bad);
    w_err_code = ERR_NONE;
    if (w_csum_bad) begin
      w_err_code = ERR_CSUM;
    end else if (r_addr_bad) begin
      w_err_code = ERR_ADDR;
    end else if (r_pad_bad) begin
      w_err_code = ERR_PAD;
    end else begin
      w_err_code = ERR_NONE;
    end
  end

  // Next-state logic; byte-consuming states advance only on a transfer.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_xfer && (i_in_data == CMD_WRITE)) begin
          w_next_state = S_ADDR;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_ADDR: begin
        if (w_xfer) begin
          w_next_state = S_DATA;
        end else begin
          w_next_state = S_ADDR;
        end
      end
      S_DATA: begin
        if (w_xfer && (r_cnt == LAST_DATA)) begin
          w_next_state = S_CSUM;
        end else begin
          w_next_state = S_DATA;
        end
      end
      S_CSUM: begin
        if (w_xfer && w_frame_ok) begin
          w_next_state = S_WRITE;
        end else if (w_xfer) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_CSUM;
        end
      end
      S_WRITE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Frame datapath, write port, hold control, error and line counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_frame_addr    <= '0;
      r_shift         <= '0;
      r_xor           <= 8'h00;
      r_cnt           <= 3'd0;
      r_addr_bad      <= 1'b0;
      r_pad_bad       <= 1'b0;
      o_wr_en         <= 1'b0;
      o_wr_addr       <= '0;
      o_wr_line       <= '0;
      o_core_hold     <= 1'b1;
      o_busy          <= 1'b0;
      o_err           <= ERR_NONE;
      o_lines_written <= 5'd0;
    end else begin
      o_wr_en <= 1'b0;
      o_busy  <= (w_next_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_xfer && (i_in_data == CMD_WRITE)) begin
            r_shift     <= '0;
            r_xor       <= 8'h00;
            r_cnt       <= 3'd0;
            r_addr_bad  <= 1'b0;
            r_pad_bad   <= 1'b0;
            o_err       <= ERR_NONE;
            o_core_hold <= 1'b1;
          end else if (w_xfer && (i_in_data == CMD_RUN)) begin
            o_core_hold <= 1'b0;
          end
        end
        S_ADDR: begin
          if (w_xfer) begin
            r_frame_addr <= i_in_data[ADDR_W-1:0];
            r_addr_bad   <= |i_in_data[7:ADDR_W];
            r_xor        <= r_xor ^ i_in_data;
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_shift <= {r_shift[LINE_W-9:0], i_in_data};
            r_xor   <= r_xor ^ i_in_data;
            if (r_cnt == 3'd0) begin
              r_pad_bad <= |i_in_data[7:6];
            end
            if (r_cnt == LAST_DATA) begin
              r_cnt <= 3'd0;
            end else begin
              r_cnt <= r_cnt + 3'd1;
            end
          end
        end
        S_CSUM: begin
          if (w_xfer && w_frame_ok) begin
            o_wr_en   <= 1'b1;
            o_wr_addr <= r_frame_addr;
            o_wr_line <= r_shift;
          end else if (w_xfer) begin
            o_err <= w_err_code;
          end
        end
        S_WRITE: begin
          o_lines_written <= o_lines_written + 5'd1;
        end
        default: begin
          o_wr_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed scenarios plus randomized
// frames, compared against a frame-level reference model.
module tb_prog_loader;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [7:0]  i_in_data;
  logic        i_in_valid;
  logic        o_in_ready;
  logic        o_wr_en;
  logic [3:0]  o_wr_addr;
  logic [45:0] o_wr_line;
  logic        o_core_hold;
  logic        o_busy;
  logic [1:0]  o_err;
  logic [4:0]  o_lines_written;

  int n_vec = 0;
  int n_err = 0;
  int wr_pulses = 0;

  logic [7:0] fr [0:8];

  int          m_count;
  logic [1:0]  m_err;
  logic        m_hold;
  logic [3:0]  m_addr;
  logic [45:0] m_line;
  bit          m_ok;

  prog_loader #(.ADDR_W(4), .LINE_W(46)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_in_data(i_in_data), .i_in_valid(i_in_valid),
    .o_in_ready(o_in_ready), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr),
    .o_wr_line(o_wr_line), .o_core_hold(o_core_hold), .o_busy(o_busy),
    .o_err(o_err), .o_lines_written(o_lines_written)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_wr_en === 1'b1) wr_pulses++;
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic model_reset();
    m_count = 0; m_err = 2'd0; m_hold = 1'b1; m_addr = 4'd0; m_line = 46'd0; m_ok = 1'b0;
  endtask

  // Reference: judge a whole frame from its bytes.
  task automatic model_frame();
    logic [7:0]  x;
    logic [47:0] acc;
    x = 8'h00;
    acc = 48'd0;
    for (int i = 1; i <= 7; i++) x = x ^ fr[i];
    for (int i = 2; i <= 7; i++) acc = acc * 256 + 48'(fr[i]);
    m_hold = 1'b1;
    if (fr[8] != x)        m_err = 2'd3;
    else if (fr[1] >= 16)  m_err = 2'd1;
    else if (fr[2] >= 64)  m_err = 2'd2;
    else                   m_err = 2'd0;
    m_ok = (m_err == 2'd0);
    if (m_ok) begin
      m_count = (m_count + 1) % 32;
      m_addr  = fr[1][3:0];
      m_line  = acc[45:0];
    end
  endtask

  task automatic fix_csum();
    logic [7:0] x;
    x = 8'h00;
    for (int i = 1; i <= 7; i++) x = x ^ fr[i];
    fr[8] = x;
  endtask

  task automatic rand_good();
    fr[0] = 8'hA5;
    fr[1] = 8'($urandom_range(0, 15));
    fr[2] = 8'($urandom_range(0, 63));
    for (int i = 3; i <= 7; i++) fr[i] = 8'($urandom_range(0, 255));
    fix_csum();
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_stall);
    bit done;
    int k;
    i_in_valid = 1'b0;
    repeat ($urandom_range(0, max_stall)) step();
    i_in_data  = b;
    i_in_valid = 1'b1;
    done = 1'b0;
    k = 0;
    while (!done && k < 50) begin
      done = o_in_ready;
      step();
      k++;
    end
    i_in_valid = 1'b0;
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL send_byte timeout: in_ready stuck at %b, required 1", o_in_ready);
    end
  endtask

  task automatic send_frame(input int max_stall);
    for (int i = 0; i <= 8; i++) send_byte(fr[i], max_stall);
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_in_valid = 1'b0; i_in_data = 8'h00;
    repeat (2) step();
    i_rst = 1'b0;
    model_reset();
    n_vec++;
    if ({o_in_ready, o_wr_en, o_wr_addr, o_wr_line, o_core_hold, o_busy, o_err, o_lines_written}
        !== {1'b1, 1'b0, 4'd0, 46'd0, 1'b1, 1'b0, 2'd0, 5'd0}) begin
      n_err++;
      $display("FAIL reset_values: got rdy=%b we=%b a=%h l=%h hold=%b busy=%b err=%0d cnt=%0d, required 1 0 0 0 1 0 0 0",
               o_in_ready, o_wr_en, o_wr_addr, o_wr_line, o_core_hold, o_busy, o_err, o_lines_written);
    end
  endtask

  task automatic test_good_frame();
    int p0;
    fr[0] = 8'hA5; fr[1] = 8'h03; fr[2] = 8'h12; fr[3] = 8'h34; fr[4] = 8'h56;
    fr[5] = 8'h78; fr[6] = 8'h9A; fr[7] = 8'hBC; fr[8] = 8'h2D;
    p0 = wr_pulses;
    send_frame(0);
    model_frame();
    n_vec++;
    if ({o_wr_en, o_in_ready, o_busy} !== 3'b101) begin
      n_err++; $display("FAIL good_write_cycle: got we/rdy/busy=%b required 101", {o_wr_en, o_in_ready, o_busy});
    end
    n_vec++;
    if (o_wr_addr !== 4'd3 || o_wr_line !== 46'h123456789ABC) begin
      n_err++; $display("FAIL good_write_data: got %h/%h required 3/123456789abc", o_wr_addr, o_wr_line);
    end
    step();
    n_vec++;
    if (o_lines_written !== 5'd1 || o_err !== 2'd0 || o_core_hold !== 1'b1 || o_busy !== 1'b0) begin
      n_err++; $display("FAIL good_after: got cnt=%0d err=%0d hold=%b busy=%b required 1 0 1 0",
                        o_lines_written, o_err, o_core_hold, o_busy);
    end
    n_vec++;
    if (wr_pulses - p0 !== 1) begin
      n_err++; $display("FAIL good_pulses: got %0d required 1", wr_pulses - p0);
    end
  endtask

  task automatic test_bad_checksum();
    int p0;
    p0 = wr_pulses;
    fr[8] = 8'h2C;
    send_frame(0);
    model_frame();
    n_vec++;
    if (o_wr_en !== 1'b0 || o_busy !== 1'b0) begin
      n_err++; $display("FAIL badcsum_nowrite: got we=%b busy=%b required 0 0", o_wr_en, o_busy);
    end
    step();
    n_vec++;
    if (o_err !== 2'd3 || o_lines_written !== 5'(m_count) || wr_pulses != p0) begin
      n_err++; $display("FAIL badcsum_err: got err=%0d cnt=%0d pulses=%0d required 3 %0d 0",
                        o_err, o_lines_written, wr_pulses - p0, m_count);
    end
    fr[8] = 8'h2D;
    send_frame(0);
    model_frame();
    n_vec++;
    if (o_wr_en !== 1'b1 || o_wr_line !== m_line) begin
      n_err++; $display("FAIL recover_write: got we=%b line=%h required 1 %h", o_wr_en, o_wr_line, m_line);
    end
    step();
    n_vec++;
    if (o_err !== 2'd0 || o_lines_written !== 5'd2) begin
      n_err++; $display("FAIL recover_err: got err=%0d cnt=%0d required 0 2", o_err, o_lines_written);
    end
  endtask

  task automatic test_bad_addr_pad();
    int p0;
    logic [1:0] exp_err;
    for (int v = 0; v < 3; v++) begin
      fr[1] = (v == 1) ? 8'h03 : 8'h13;
      fr[2] = (v == 0) ? 8'h12 : 8'hD2;
      exp_err = (v == 1) ? 2'd2 : 2'd1;
      fix_csum();
      p0 = wr_pulses;
      send_frame(1);
      model_frame();
      step();
      n_vec++;
      if (o_err !== exp_err || o_err !== m_err || wr_pulses != p0) begin
        n_err++; $display("FAIL addr_pad_%0d: got err=%0d pulses=%0d required %0d 0",
                          v, o_err, wr_pulses - p0, exp_err);
      end
    end
    n_vec++;
    if (fr[8] !== 8'h0D && o_lines_written !== 5'd2) begin
      n_err++; $display("FAIL addr_pad_count: got %0d required 2", o_lines_written);
    end
  endtask

  task automatic test_run_hold();
    int p0;
    send_byte(8'h5A, 0);
    m_hold = 1'b0;
    n_vec++;
    if (o_core_hold !== 1'b0 || o_busy !== 1'b0) begin
      n_err++; $display("FAIL run_release: got hold=%b busy=%b required 0 0", o_core_hold, o_busy);
    end
    send_byte(8'h00, 0);
    step();
    n_vec++;
    if (o_core_hold !== 1'b0 || o_busy !== 1'b0 || o_err !== m_err) begin
      n_err++; $display("FAIL stray_byte: got hold=%b busy=%b err=%0d required 0 0 %0d",
                        o_core_hold, o_busy, o_err, m_err);
    end
    rand_good();
    send_byte(fr[0], 0);
    n_vec++;
    if (o_core_hold !== 1'b1 || o_busy !== 1'b1 || o_err !== 2'd0) begin
      n_err++; $display("FAIL hold_reassert: got hold=%b busy=%b err=%0d required 1 1 0",
                        o_core_hold, o_busy, o_err);
    end
    p0 = wr_pulses;
    for (int i = 1; i <= 8; i++) send_byte(fr[i], 0);
    model_frame();
    step();
    n_vec++;
    if (o_core_hold !== 1'b1 || wr_pulses - p0 != 1 || o_wr_addr !== m_addr) begin
      n_err++; $display("FAIL hold_after_frame: got hold=%b pulses=%0d addr=%h required 1 1 %h",
                        o_core_hold, wr_pulses - p0, o_wr_addr, m_addr);
    end
  endtask

  task automatic test_backpressure();
    int p0;
    for (int r = 0; r < 4; r++) begin
      rand_good();
      p0 = wr_pulses;
      send_frame(3);
      model_frame();
      n_vec++;
      if (o_wr_en !== 1'b1 || o_in_ready !== 1'b0 || o_wr_addr !== m_addr || o_wr_line !== m_line) begin
        n_err++; $display("FAIL stall_write: got we=%b rdy=%b a=%h l=%h required 1 0 %h %h",
                          o_wr_en, o_in_ready, o_wr_addr, o_wr_line, m_addr, m_line);
      end
      i_in_data = 8'hA5;
      i_in_valid = 1'b1;
      step();
      i_in_valid = 1'b0;
      n_vec++;
      if (o_busy !== 1'b0 || o_in_ready !== 1'b1 || o_lines_written !== 5'(m_count) || wr_pulses - p0 != 1) begin
        n_err++; $display("FAIL stall_not_consumed: got busy=%b rdy=%b cnt=%0d pulses=%0d required 0 1 %0d 1",
                          o_busy, o_in_ready, o_lines_written, wr_pulses - p0, m_count);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int p0;
    send_byte(8'h5A, 0);
    rand_good();
    p0 = wr_pulses;
    for (int i = 0; i <= 5; i++) send_byte(fr[i], 1);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    model_reset();
    n_vec++;
    if (o_core_hold !== 1'b1 || o_busy !== 1'b0 || o_lines_written !== 5'd0 || o_wr_en !== 1'b0) begin
      n_err++; $display("FAIL midreset_state: got hold=%b busy=%b cnt=%0d we=%b required 1 0 0 0",
                        o_core_hold, o_busy, o_lines_written, o_wr_en);
    end
    rand_good();
    send_frame(0);
    model_frame();
    n_vec++;
    if (o_wr_en !== 1'b1 || o_wr_addr !== m_addr || o_wr_line !== m_line) begin
      n_err++; $display("FAIL midreset_write: got we=%b a=%h l=%h required 1 %h %h",
                        o_wr_en, o_wr_addr, o_wr_line, m_addr, m_line);
    end
    step();
    n_vec++;
    if (wr_pulses - p0 != 1 || o_lines_written !== 5'd1) begin
      n_err++; $display("FAIL midreset_pulses: got pulses=%0d cnt=%0d required 1 1", wr_pulses - p0, o_lines_written);
    end
    rand_good();
    send_frame(0);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    model_reset();
    n_vec++;
    if (o_wr_en !== 1'b0 || o_busy !== 1'b0 || o_lines_written !== 5'd0) begin
      n_err++; $display("FAIL reset_in_write: got we=%b busy=%b cnt=%0d required 0 0 0", o_wr_en, o_busy, o_lines_written);
    end
  endtask

  task automatic test_random();
    int p0;
    int kind;
    for (int n = 0; n < 40; n++) begin
      rand_good();
      kind = $urandom_range(0, 3);
      if (kind == 2) fr[1] = fr[1] | 8'(16 << $urandom_range(0, 3));
      if (kind == 3) fr[2] = fr[2] | 8'(64 << $urandom_range(0, 1));
      if (kind >= 2) fix_csum();
      if (kind == 1) fr[8] = fr[8] ^ 8'(1 << $urandom_range(0, 7));
      p0 = wr_pulses;
      send_frame(2);
      model_frame();
      n_vec++;
      if (o_wr_en !== m_ok || (m_ok && (o_wr_addr !== m_addr || o_wr_line !== m_line))) begin
        n_err++; $display("FAIL random_%0d_write: got we=%b a=%h l=%h required %b %h %h",
                          n, o_wr_en, o_wr_addr, o_wr_line, m_ok, m_addr, m_line);
      end
      step();
      n_vec++;
      if (o_err !== m_err || o_lines_written !== 5'(m_count) || o_core_hold !== m_hold || wr_pulses - p0 != int'(m_ok)) begin
        n_err++; $display("FAIL random_%0d_state: got err=%0d cnt=%0d hold=%b required %0d %0d %b",
                          n, o_err, o_lines_written, o_core_hold, m_err, m_count, m_hold);
      end
    end
  endtask

  task automatic test_wrap();
    int p0;
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    model_reset();
    p0 = wr_pulses;
    for (int n = 0; n < 32; n++) begin
      rand_good();
      send_frame(0);
      model_frame();
      step();
      if (n == 30) begin
        n_vec++;
        if (o_lines_written !== 5'd31) begin
          n_err++; $display("FAIL wrap_31: got %0d required 31", o_lines_written);
        end
      end
    end
    n_vec++;
    if (o_lines_written !== 5'd0 || m_count != 0 || wr_pulses - p0 != 32) begin
      n_err++; $display("FAIL wrap_zero: got cnt=%0d pulses=%0d required 0 32", o_lines_written, wr_pulses - p0);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_bad_addr_pad();
    test_run_hold();
    test_backpressure();
    test_reset_mid_frame();
    test_random();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
